// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU share arbiter.
package alu_arb_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int SELW_DEF  = 2;

    // likeALU operation codes
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester/consumer bundle for the ALU share arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 5,
    parameter int SELW  = 2
);
    logic [1:0]       req;
    logic [WIDTH-1:0] inp_A0;
    logic [WIDTH-1:0] inp_B0;
    logic [SELW-1:0]  select0;
    logic [WIDTH-1:0] inp_A1;
    logic [WIDTH-1:0] inp_B1;
    logic [SELW-1:0]  select1;
    logic [1:0]       ack;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res;
    logic             res_ready;
    logic             busy;

    modport master (
        output req, inp_A0, inp_B0, select0, inp_A1, inp_B1, select1, res_ready,
        input  ack, res_valid, res_id, res, busy
    );

    modport slave (
        input  req, inp_A0, inp_B0, select0, inp_A1, inp_B1, select1, res_ready,
        output ack, res_valid, res_id, res, busy
    );
endinterface

// File: rtl/likeALU.sv
// Small combinational ALU: add, subtract, and, or; results wrap at WIDTH bits.
module likeALU
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SELW  = SELW_DEF
) (
    input  logic [WIDTH-1:0] inp_A,
    input  logic [WIDTH-1:0] inp_B,
    input  logic [SELW-1:0]  select,
    output logic [WIDTH-1:0] out
);

    localparam logic [SELW-1:0] SEL_ADD = SELW'(OP_ADD);
    localparam logic [SELW-1:0] SEL_SUB = SELW'(OP_SUB);
    localparam logic [SELW-1:0] SEL_AND = SELW'(OP_AND);
    localparam logic [SELW-1:0] SEL_OR  = SELW'(OP_OR);

    always_comb begin
        out = '0;
        case (select)
            SEL_ADD: out = inp_A + inp_B;
            SEL_SUB: out = inp_A - inp_B;
            SEL_AND: out = inp_A & inp_B;
            SEL_OR:  out = inp_A | inp_B;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one likeALU between two requesters,
// with a registered result held until the consumer accepts it.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SELW  = SELW_DEF
) (
    input logic          clk,
    input logic          rst_n,
    alu_share_arbiter_if.slave bus
);

    arb_state_e       state_q,     state_d;
    logic [1:0]       ack_q,       ack_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q,    res_id_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             last_id_q,   last_id_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic [SELW-1:0]  sel_q,       sel_d;

    logic             winner;
    logic [WIDTH-1:0] alu_y;

    likeALU #(.WIDTH(WIDTH), .SELW(SELW)) u_alu (
        .inp_A  (op_a_q),
        .inp_B  (op_b_q),
        .select (sel_q),
        .out    (alu_y)
    );

    // On a tie the requester that did not own the last accepted result wins.
    assign winner = (bus.req == 2'b11) ? ~last_id_q : bus.req[1];

    always_comb begin
        state_d     = state_q;
        ack_d       = 2'b00;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_d       = res_q;
        last_id_d   = last_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sel_d       = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    op_a_d   = winner ? bus.inp_A1  : bus.inp_A0;
                    op_b_d   = winner ? bus.inp_B1  : bus.inp_B0;
                    sel_d    = winner ? bus.select1 : bus.select0;
                    ack_d    = winner ? 2'b10 : 2'b01;
                    res_id_d = winner;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d       = alu_y;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    last_id_d   = res_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= 2'b00;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_q       <= '0;
            last_id_q   <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_q       <= res_d;
            last_id_q   <= last_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sel_q       <= sel_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; ALU ops: 00 add, 01 sub, 10 and, 11 or.
module tb_alu_share_arbiter;

    localparam int WIDTH = 5;
    localparam int SELW  = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.req = 2'b00;
        bus.inp_A0 = '0; bus.inp_B0 = '0; bus.select0 = '0;
        bus.inp_A1 = '0; bus.inp_B1 = '0; bus.select1 = '0;
        bus.res_ready = 1'b0;

        // reset state
        step(); step();
        check("rst_ack",   32'(bus.ack),       32'h0);
        check("rst_valid", 32'(bus.res_valid), 32'h0);
        check("rst_id",    32'(bus.res_id),    32'h0);
        check("rst_res",   32'(bus.res),       32'h0);
        check("rst_busy",  32'(bus.busy),      32'h0);
        rst_n = 1'b1;

        // single request from requester 0: 10101 + 11111 = 10100 (wrap)
        bus.req = 2'b01; bus.inp_A0 = 5'b10101; bus.inp_B0 = 5'b11111; bus.select0 = 2'b00;
        bus.res_ready = 1'b1;
        step();
        check("s0_ack",     32'(bus.ack),       32'h1);
        check("s0_busy",    32'(bus.busy),      32'h1);
        check("s0_valid0",  32'(bus.res_valid), 32'h0);
        bus.req = 2'b00;
        step();
        check("s0_ack_off", 32'(bus.ack),       32'h0);
        check("s0_valid",   32'(bus.res_valid), 32'h1);
        check("s0_res",     32'(bus.res),       32'h14);
        check("s0_id",      32'(bus.res_id),    32'h0);
        step();
        check("s0_done",    32'(bus.res_valid), 32'h0);
        check("s0_idle",    32'(bus.busy),      32'h0);
        check("s0_retain",  32'(bus.res),       32'h14);

        // res_ready with nothing pending is ignored
        step();
        check("rdy_idle_busy",  32'(bus.busy),      32'h0);
        check("rdy_idle_valid", 32'(bus.res_valid), 32'h0);

        // both requesting after reset: grants alternate starting with 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.inp_A0 = 5'b00011; bus.inp_B0 = 5'b00101; bus.select0 = 2'b01;  // 3-5 -> 11110
        bus.inp_A1 = 5'b00110; bus.inp_B1 = 5'b00101; bus.select1 = 2'b10;  // and -> 00100
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_ack", 32'(bus.ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check("rr_valid", 32'(bus.res_valid), 32'h1);
            check("rr_id",    32'(bus.res_id),    (k % 2 == 0) ? 32'h0 : 32'h1);
            check("rr_res",   32'(bus.res),       (k % 2 == 0) ? 32'h1E : 32'h04);
            step();
            check("rr_done",  32'(bus.res_valid), 32'h0);
        end
        bus.req = 2'b00;

        // requester 1 with back-pressure: 11111 | 11111 = 11111
        bus.req = 2'b10; bus.inp_A1 = 5'b11111; bus.inp_B1 = 5'b11111; bus.select1 = 2'b11;
        bus.res_ready = 1'b0;
        step();
        check("bp_ack", 32'(bus.ack), 32'h2);
        bus.req = 2'b00;
        step();
        check("bp_valid", 32'(bus.res_valid), 32'h1);
        check("bp_res",   32'(bus.res),       32'h1F);
        check("bp_id",    32'(bus.res_id),    32'h1);
        bus.inp_A1 = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", 32'(bus.res_valid), 32'h1);
            check("bp_hold_res",   32'(bus.res),       32'h1F);
            check("bp_hold_id",    32'(bus.res_id),    32'h1);
        end
        bus.res_ready = 1'b1;
        step();
        check("bp_clear",  32'(bus.res_valid), 32'h0);
        check("bp_retain", 32'(bus.res),       32'h1F);
        check("bp_idle",   32'(bus.busy),      32'h0);

        // operand change after capture: 01100 - 00011 = 01001
        bus.req = 2'b01; bus.inp_A0 = 5'b01100; bus.inp_B0 = 5'b00011; bus.select0 = 2'b01;
        step();
        check("cap_ack", 32'(bus.ack), 32'h1);
        bus.inp_A0 = 5'b00000; bus.req = 2'b00;
        step();
        check("cap_valid", 32'(bus.res_valid), 32'h1);
        check("cap_res",   32'(bus.res),       32'h09);
        step();

        // reset in HOLD: 00001 + 00001 = 00010 is in flight
        bus.req = 2'b01; bus.inp_A0 = 5'b00001; bus.inp_B0 = 5'b00001; bus.select0 = 2'b00;
        bus.res_ready = 1'b0;
        step();
        bus.req = 2'b00;
        step();
        check("hr_valid", 32'(bus.res_valid), 32'h1);
        check("hr_res",   32'(bus.res),       32'h02);
        #3 rst_n = 1'b0;
        #1;
        check("hr_async_valid", 32'(bus.res_valid), 32'h0);
        check("hr_async_ack",   32'(bus.ack),       32'h0);
        check("hr_async_busy",  32'(bus.busy),      32'h0);
        check("hr_async_res",   32'(bus.res),       32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("hr_post_valid", 32'(bus.res_valid), 32'h0);
        check("hr_post_ack",   32'(bus.ack),       32'h0);
        check("hr_post_busy",  32'(bus.busy),      32'h0);
        bus.inp_A0 = 5'b00100; bus.inp_B0 = 5'b00001; bus.select0 = 2'b00;  // 00101
        bus.inp_A1 = 5'b01111; bus.inp_B1 = 5'b00011; bus.select1 = 2'b10;  // 00011
        bus.req = 2'b11;
        step();
        check("hr_tie_ack", 32'(bus.ack),    32'h1);
        check("hr_tie_id",  32'(bus.res_id), 32'h0);
        bus.req = 2'b00; bus.res_ready = 1'b1;
        step();
        check("hr_tie_valid", 32'(bus.res_valid), 32'h1);
        check("hr_tie_res",   32'(bus.res),       32'h05);
        step();
        check("hr_tie_done", 32'(bus.res_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
